// File: rtl/core_pkg.sv
// core_pkg: shared write-back select codes, payload struct and skid FSM states
package core_pkg;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        we;
  } wb_payload;
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} skid_state_e;
endpackage

// File: rtl/mem_wb_skid_if.sv
// mem_wb_skid_if: MEM-side and WB-side handshake plus payload of the MEM/WB buffer
interface mem_wb_skid_if #(parameter int N = 32, parameter int RW = 5);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_alu;
  logic [N-1:0]  in_mem;
  logic [N-1:0]  in_pc4;
  logic [N-1:0]  in_imm;
  logic [1:0]    in_sel;
  logic [RW-1:0] in_rd;
  logic          in_we;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_a;
  logic [N-1:0]  out_b;
  logic [N-1:0]  out_c;
  logic [N-1:0]  out_d;
  logic [1:0]    out_sel;
  logic [RW-1:0] out_rd;
  logic          out_we;
  modport master (
    output in_valid, in_alu, in_mem, in_pc4, in_imm, in_sel, in_rd, in_we, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_c, out_d, out_sel, out_rd, out_we
  );
  modport slave (
    input  in_valid, in_alu, in_mem, in_pc4, in_imm, in_sel, in_rd, in_we, out_ready,
    output in_ready, out_valid, out_a, out_b, out_c, out_d, out_sel, out_rd, out_we
  );
endinterface

// File: rtl/wb_entry_reg.sv
// wb_entry_reg: loadable payload register with synchronous active-low clear
module wb_entry_reg #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] data_d, data_q;
  // hold unless loaded
  always_comb data_d = ld ? d : data_q;
  // clear on reset, otherwise take next value
  always_ff @(posedge clk) data_q <= !rst ? '0 : data_d;
  assign q = data_q;
endmodule

// File: rtl/mem_wb_skid.sv
// mem_wb_skid: two-entry skid MEM/WB register with retire counter; MEM_WB_KILL_X0_EN drops x0 writes at capture
module mem_wb_skid import core_pkg::*; #(
  parameter int N  = 32,
  parameter int RW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  mem_wb_skid_if.slave      bus,
  output logic [31:0]       retired
);
  localparam int W = 4 * N + RW + 3;
  skid_state_e state_d, state_q;
  logic [31:0] retired_d, retired_q;
  logic in_fire, out_fire, we_cap, main_ld, skid_ld, main_we;
  logic [W-1:0] in_word, main_in, main_q, skid_q;
`ifdef MEM_WB_KILL_X0_EN
  assign we_cap = bus.in_we & (|bus.in_rd);
`else
  assign we_cap = bus.in_we;
`endif
  // next-state, entry load enables and retire count
  always_comb begin
    in_fire   = bus.in_valid & bus.in_ready;
    out_fire  = bus.out_valid & bus.out_ready;
    in_word   = {bus.in_alu, bus.in_mem, bus.in_pc4, bus.in_imm, bus.in_sel, bus.in_rd, we_cap};
    main_ld   = (state_q == S_EMPTY) ? in_fire :
                (state_q == S_ONE)   ? in_fire & out_fire : out_fire;
    main_in   = (state_q == S_FULL) ? skid_q : in_word;
    skid_ld   = (state_q == S_ONE) & in_fire & ~out_fire;
    state_d   = flush                ? S_EMPTY :
                (state_q == S_EMPTY) ? (in_fire ? S_ONE : S_EMPTY) :
                (state_q == S_ONE)   ? (in_fire & ~out_fire ? S_FULL :
                                        ~in_fire & out_fire ? S_EMPTY : S_ONE) :
                                       (out_fire ? S_ONE : S_FULL);
    retired_d = retired_q + {31'b0, out_fire};
  end
  // state and retire counter
  always_ff @(posedge clk) begin
    state_q   <= !rst ? S_EMPTY : state_d;
    retired_q <= !rst ? '0 : retired_d;
  end
  wb_entry_reg #(.W(W)) u_main (.clk, .rst, .ld(main_ld), .d(main_in), .q(main_q));
  wb_entry_reg #(.W(W)) u_skid (.clk, .rst, .ld(skid_ld), .d(in_word), .q(skid_q));
  assign bus.in_ready  = state_q != S_FULL;
  assign bus.out_valid = state_q != S_EMPTY;
  assign {bus.out_a, bus.out_b, bus.out_c, bus.out_d, bus.out_sel, bus.out_rd, main_we} = main_q;
  assign bus.out_we    = main_we & bus.out_valid;
  assign retired       = retired_q;
endmodule

// File: tb/tb_mem_wb_skid.sv
// tb_mem_wb_skid: directed scoreboard bench for the MEM/WB skid buffer
module tb_mem_wb_skid;
  import core_pkg::*;
  logic clk = 0, rst = 0, flush = 0;
  logic [31:0] retired;
  mem_wb_skid_if #(.N(32), .RW(5)) bus();
  mem_wb_skid #(.N(32), .RW(5)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus.slave), .retired(retired));
  always #5 clk = ~clk;
  wb_payload q[$];
  wb_payload p;
  int checks = 0, errors = 0;
  logic [31:0] exp_ret = 0;
  bit fin;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic wb_payload rnd();
    wb_payload r;
    r.alu = $urandom; r.mem = $urandom; r.pc4 = $urandom; r.imm = $urandom;
    r.sel = 2'($urandom); r.rd = 5'($urandom_range(1, 31)); r.we = 1'($urandom);
    return r;
  endfunction
  task automatic drive(wb_payload r);
    bus.in_alu = r.alu; bus.in_mem = r.mem; bus.in_pc4 = r.pc4; bus.in_imm = r.imm;
    bus.in_sel = r.sel; bus.in_rd = r.rd; bus.in_we = r.we;
  endtask
  function automatic wb_payload cap();
    wb_payload r;
    r.alu = bus.in_alu; r.mem = bus.in_mem; r.pc4 = bus.in_pc4; r.imm = bus.in_imm;
    r.sel = bus.in_sel; r.rd = bus.in_rd;
`ifdef MEM_WB_KILL_X0_EN
    r.we = bus.in_we & (bus.in_rd != 0);
`else
    r.we = bus.in_we;
`endif
    return r;
  endfunction
  task automatic rcheck(string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_ready"}, 32'(bus.in_ready), 1);
    chk({tag, "_a"}, bus.out_a, 0);
    chk({tag, "_b"}, bus.out_b, 0);
    chk({tag, "_c"}, bus.out_c, 0);
    chk({tag, "_d"}, bus.out_d, 0);
    chk({tag, "_sel"}, 32'(bus.out_sel), 0);
    chk({tag, "_rd"}, 32'(bus.out_rd), 0);
    chk({tag, "_we"}, 32'(bus.out_we), 0);
    chk({tag, "_retired"}, retired, 0);
  endtask
  task automatic tick();
    bit fout;
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("retired", retired, exp_ret);
    if (q.size() > 0) begin
      chk("out_a", bus.out_a, q[0].alu);
      chk("out_b", bus.out_b, q[0].mem);
      chk("out_c", bus.out_c, q[0].pc4);
      chk("out_d", bus.out_d, q[0].imm);
      chk("out_sel", 32'(bus.out_sel), 32'(q[0].sel));
      chk("out_rd", 32'(bus.out_rd), 32'(q[0].rd));
      chk("out_we", 32'(bus.out_we), 32'(q[0].we));
    end else chk("out_we_idle", 32'(bus.out_we), 0);
    fin  = rst && bus.in_valid && q.size() < 2;
    fout = rst && bus.out_ready && q.size() > 0;
    p = cap();
    @(posedge clk); #1;
    if (!rst) begin
      q.delete();
      exp_ret = 0;
      fin = 0;
    end else begin
      if (fout) begin void'(q.pop_front()); exp_ret++; end
      if (flush) begin q.delete(); fin = 0; end
      else if (fin) q.push_back(p);
    end
  endtask
  initial begin
    bus.in_valid = 0; bus.out_ready = 0;
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    rcheck("reset");
    rst = 1;
    p = '0; p.alu = 32'h10; p.sel = WB_ALU; p.rd = 5; p.we = 1;
    drive(p); bus.in_valid = 1; bus.out_ready = 1;
    tick();
    bus.in_valid = 0;
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_a", bus.out_a, 32'h10);
    chk("t1_sel", 32'(bus.out_sel), 0);
    chk("t1_rd", 32'(bus.out_rd), 5);
    chk("t1_we", 32'(bus.out_we), 1);
    tick();
    chk("t1_retired", retired, 1);
    bus.out_ready = 0;
    for (int i = 1; i <= 3; i++) begin
      p = rnd(); p.imm = i; drive(p); bus.in_valid = 1;
      tick();
      if (i == 2) chk("t2_ready_low", 32'(bus.in_ready), 0);
    end
    chk("t2_held_ready", 32'(bus.in_ready), 0);
    bus.out_ready = 1;
    chk("t2_first_imm", bus.out_d, 1);
    for (int k = 0; k < 10 && bus.in_valid; k++) begin
      tick();
      if (fin) bus.in_valid = 0;
    end
    chk("t2_third_accepted", 32'(bus.in_valid), 0);
    repeat (4) tick();
    chk("t2_retired", retired, 4);
    bus.in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      drive(rnd());
      tick();
      chk("t3_ready", 32'(bus.in_ready), 1);
    end
    bus.in_valid = 0;
    repeat (2) tick();
    chk("t3_retired", retired, 12);
    bus.out_ready = 0; bus.in_valid = 1;
    drive(rnd()); tick();
    drive(rnd()); tick();
    chk("t4_full", 32'(bus.in_ready), 0);
    drive(rnd()); flush = 1; bus.out_ready = 1;
    tick();
    flush = 0; bus.in_valid = 0;
    chk("t4_valid", 32'(bus.out_valid), 0);
    chk("t4_ready", 32'(bus.in_ready), 1);
    repeat (3) tick();
    chk("t4_retired", retired, 13);
    p = rnd(); p.rd = 0; p.we = 1; drive(p);
    bus.in_valid = 1; bus.out_ready = 1;
    tick();
    bus.in_valid = 0;
`ifdef MEM_WB_KILL_X0_EN
    chk("t5_x0_we", 32'(bus.out_we), 0);
`else
    chk("t5_x0_we", 32'(bus.out_we), 1);
`endif
    tick();
    bus.out_ready = 0; bus.in_valid = 1;
    drive(rnd()); tick();
    drive(rnd()); tick();
    chk("t6_full", 32'(bus.in_ready), 0);
    rst = 0;
    tick();
    rst = 1; bus.in_valid = 0;
    rcheck("mid_rst");
    bus.out_ready = 1;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
